iq_frame_packer: RTL

Downstream stage of the IQ/time register stage; consumes its registered IQ word, 32-bit sample time and single-cycle valid.
Buffers samples in a first-word-fall-through FIFO and emits fixed-length frames on a valid/ready stream: header word, time of first sample, then FRAME_LEN IQ words.
Feeds the packet transmitter / MCU readout path at 48 MHz.

---
 rtl/iq_frame_packer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/iq_frame_packer.sv
// iq_frame_packer
//    Buffers registered IQ samples with their time stamps in a
//    first-word-fall-through FIFO. Emits fixed-length frames on a
//    valid/ready stream: a header word, the time of the first sample,
//    then FRAME_LEN IQ words.
//
// Ports
//    clk, rst_n    system clock (48 MHz), asynchronous active-low reset
//    clk_en        input-side enable; samples are accepted only when high
//    dat_IQ        IQ sample {I[31:16], Q[15:0]}
//    dat_TIME      sample time, low 32 bits of the real-time counter
//    valid         sample strobe
//    out_data      frame stream word
//    out_valid     out_data valid
//    out_ready     sink ready; a word transfers on out_valid & out_ready
//    out_sop       marks the header word
//    out_eop       marks the last IQ word of a frame
//    overflow      sticky; set by the first dropped sample
//    drop_cnt      saturating count of dropped samples
//    fifo_level    current FIFO occupancy
module iq_frame_packer #(
   parameter int          FRAME_LEN = 64,
   parameter int          FIFO_AW   = 8,
   parameter logic [15:0] SYNC      = 16'hA5C3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clk_en,
   input  logic [31:0]        dat_IQ,
   input  logic [31:0]        dat_TIME,
   input  logic               valid,
   output logic [31:0]        out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sop,
   output logic               out_eop,
   output logic               overflow,
   output logic [15:0]        drop_cnt,
   output logic [FIFO_AW:0]   fifo_level
);

   localparam int               DEPTH  = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0] FLEN_L  = (FIFO_AW + 1)'(FRAME_LEN);
   localparam logic [FIFO_AW:0] LAST_L  = (FIFO_AW + 1)'(FRAME_LEN - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_HDR    = 2'd1;
   localparam logic [1:0] S_TSTAMP = 2'd2;
   localparam logic [1:0] S_DATA   = 2'd3;

   logic [63:0]        mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nx;
   logic [FIFO_AW:0]   level_q, level_d;
   logic [1:0]         state_q, state_d;
   logic [FIFO_AW:0]   word_cnt_q, word_cnt_d, word_cnt_inc;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic [31:0]        out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               out_sop_q, out_sop_d;
   logic               out_eop_q, out_eop_d;
   logic               overflow_q;
   logic [15:0]        drop_cnt_q;

   logic               full, push, drop, xfer, pop;
   logic [63:0]        head, next_head;

   // Full uses the registered level, so a same-cycle pop never frees room
   // for a push.
   assign full  = (level_q == DEPTH_L);
   assign push  = valid & clk_en & ~full;
   assign drop  = valid & clk_en & full;
   assign xfer  = out_valid_q & out_ready;
   assign pop   = xfer & (state_q == S_DATA);

   assign rd_ptr_nx    = rd_ptr_q + 1'b1;
   assign head         = mem_q[rd_ptr_q];
   assign next_head    = mem_q[rd_ptr_nx];
   assign word_cnt_inc = word_cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {dat_TIME, dat_IQ};
      end
   end

   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (!push && pop) begin
         level_d = level_q - 1'b1;
      end
   end

   // Output words are registered; each transfer loads the word that
   // follows it. In DATA the popped head is replaced by the next entry,
   // which is guaranteed present because a frame starts only with
   // FRAME_LEN samples already buffered.
   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      frame_cnt_d = frame_cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      case (state_q)
         S_IDLE: begin
            if (level_q >= FLEN_L) begin
               state_d     = S_HDR;
               out_valid_d = 1'b1;
               out_sop_d   = 1'b1;
               out_eop_d   = 1'b0;
               out_data_d  = {SYNC, frame_cnt_q};
            end
         end
         S_HDR: begin
            if (xfer) begin
               state_d    = S_TSTAMP;
               out_sop_d  = 1'b0;
               out_data_d = head[63:32];
            end
         end
         S_TSTAMP: begin
            if (xfer) begin
               state_d    = S_DATA;
               word_cnt_d = '0;
               out_data_d = head[31:0];
               out_eop_d  = (LAST_L == '0);
            end
         end
         S_DATA: begin
            if (xfer) begin
               if (word_cnt_q == LAST_L) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
                  out_eop_d   = 1'b0;
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end else begin
                  word_cnt_d = word_cnt_inc;
                  out_data_d = next_head[31:0];
                  out_eop_d  = (word_cnt_inc == LAST_L);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         state_q     <= S_IDLE;
         word_cnt_q  <= '0;
         frame_cnt_q <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_nx;
         end
         level_q     <= level_d;
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1) begin
               drop_cnt_q <= drop_cnt_q + 1'b1;
            end
         end
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_sop    = out_sop_q;
   assign out_eop    = out_eop_q;
   assign overflow   = overflow_q;
   assign drop_cnt   = drop_cnt_q;
   assign fifo_level = level_q;

endmodule
